pipe_control: RTL

//  Central hazard/sequencing controller for the 5-stage Y86-64 pipeline. Generates stall/bubble

---
 rtl/pipe_control_if.sv | 53 +++++
 rtl/pipe_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_control_if.sv
// pipe_control_if
//   Bundles every signal exchanged between the Y86-64 pipeline stages and the
//   central hazard/sequencing controller.
//   master : pipeline side, drives start/stage icodes/regs/status and
//            receives the stall/bubble controls, run state and counters.
//   slave  : controller side, the mirror image of master.
//   CNT_W  : width of every performance counter.
interface pipe_control_if #(
  parameter int CNT_W = 32
) ();

  logic             start;
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       W_icode;
  logic [3:0]       E_dstM;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic             e_cnd;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             W_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             set_cc;
  logic [1:0]       run_state;
  logic [3:0]       final_stat;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mp_cnt;
  logic [CNT_W-1:0] ret_cnt;

  modport master (
    output start, D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB,
           e_cnd, m_stat, W_stat,
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
           run_state, final_stat, cycle_cnt, retire_cnt, lu_cnt, mp_cnt, ret_cnt
  );

  modport slave (
    input  start, D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB,
           e_cnd, m_stat, W_stat,
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
           run_state, final_stat, cycle_cnt, retire_cnt, lu_cnt, mp_cnt, ret_cnt
  );

endinterface

// File: rtl/pipe_control.sv
// pipe_control
//   Central hazard/sequencing controller for the 5-stage Y86-64 pipeline.
//   Produces the stall/bubble controls for the F, D, E, M and W pipeline
//   registers and the condition-code write enable, owns the IDLE/RUN/STOP
//   run-state FSM and keeps saturating performance counters.
//   Ports:
//     clk    : system clock, all state updates on the rising edge
//     reset  : synchronous active-high, returns to IDLE and clears counters
//     bus    : pipe_control_if slave modport (stage inputs, control outputs,
//              run_state, final_stat and the five performance counters)
//   Control outputs are combinational from the stage inputs and the
//   registered run state; run_state, final_stat and counters are registered.
module pipe_control #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  pipe_control_if.slave bus
);

  // Y86-64 instruction and status encodings used by the hazard terms
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] S_HLT    = 4'h2;
  localparam logic [3:0] S_ADR    = 4'h3;
  localparam logic [3:0] S_INS    = 4'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } run_state_t;

  run_state_t       state;
  logic [3:0]       final_stat;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mp_cnt;
  logic [CNT_W-1:0] ret_cnt;

  // Raw hazard terms, independent of run state
  logic lu;
  logic mp;
  logic rt;
  logic mx;
  logic wx;
  logic running;

  // Saturating increment: a counter that reaches all-ones stays there
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Decode the hazard conditions. A load/use only exists when the load
  // really writes a register, so the "no register" code never matches the
  // "no source" code in decode.
  always_comb begin
    lu = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
         (bus.E_dstM != R_NONE) &&
         ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    mp = (bus.E_icode == I_JXX) && !bus.e_cnd;
    rt = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
         (bus.M_icode == I_RET);
    mx = (bus.m_stat == S_HLT) || (bus.m_stat == S_ADR) ||
         (bus.m_stat == S_INS);
    wx = (bus.W_stat == S_HLT) || (bus.W_stat == S_ADR) ||
         (bus.W_stat == S_INS);
    running = (state == RUN);
  end

  // Pipeline control. Outside RUN the pipe is frozen: F/D/W hold, no
  // bubbles, no CC writes. In RUN a load/use stall on D takes precedence
  // over the ret bubble so D_stall and D_bubble are never both asserted.
  always_comb begin
    bus.F_stall  = 1'b1;
    bus.D_stall  = 1'b1;
    bus.W_stall  = 1'b1;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    bus.set_cc   = 1'b0;
    if (running) begin
      bus.F_stall  = lu | rt;
      bus.D_stall  = lu;
      bus.D_bubble = mp | (!lu & rt);
      bus.E_bubble = mp | lu;
      bus.M_bubble = mx | wx;
      bus.W_stall  = wx;
      bus.set_cc   = (bus.E_icode == I_OPQ) & !mx & !wx;
    end
  end

  // Run-state FSM. Reset dominates start. Once an exceptional status
  // reaches W the machine stops for good, capturing that status on the
  // same edge so software can see why execution ended.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      final_stat <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (wx) begin
            state      <= STOP;
            final_stat <= bus.W_stat;
          end
        end
        STOP: begin
          state <= STOP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Performance counters advance only while running, including the cycle
  // that moves RUN->STOP. A retirement is a real instruction (not a nop)
  // with AOK status leaving W while W is not held.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      lu_cnt     <= '0;
      mp_cnt     <= '0;
      ret_cnt    <= '0;
    end else if (running) begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if ((bus.W_stat == S_AOK) && (bus.W_icode != I_NOP) && !bus.W_stall) begin
        retire_cnt <= sat_inc(retire_cnt);
      end
      if (lu) begin
        lu_cnt <= sat_inc(lu_cnt);
      end
      if (mp) begin
        mp_cnt <= sat_inc(mp_cnt);
      end
      if (rt && !lu) begin
        ret_cnt <= sat_inc(ret_cnt);
      end
    end
  end

  assign bus.run_state  = state;
  assign bus.final_stat = final_stat;
  assign bus.cycle_cnt  = cycle_cnt;
  assign bus.retire_cnt = retire_cnt;
  assign bus.lu_cnt     = lu_cnt;
  assign bus.mp_cnt     = mp_cnt;
  assign bus.ret_cnt    = ret_cnt;

endmodule
